// File: rtl/dcache_miss_handler_pkg.sv
// Shared definitions for the D-cache miss handler: state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_miss_handler_pkg;

    localparam int ADDR_W_DEF  = 20;   // line address width
    localparam int LINE_W_DEF  = 128;  // cache line width in bits
    localparam int TIMEOUT_DEF = 31;   // max cycles in REQ before error
    localparam int CNT_W       = 5;    // REQ cycle counter width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/dcache_miss_handler.sv
// D-cache miss handler: latches one miss (plus optional dirty victim), issues a
// memory request, returns the fill line, and flags protocol/timeout errors.
// Latency: reqD_cache rises 1 cycle after miss_req is sampled; fill_valid pulses
//          1 cycle after read_ready_for_dcache. All outputs are registered.
// Backpressure: a new miss is taken only in IDLE; miss_req while busy is ignored.
// Ports:
//   clk, reset                       clock, async active-high reset
//   miss_req/miss_addr/miss_dirty    miss request from the core
//   victim_addr/victim_data          write-back victim line
//   err_clr                          clears the sticky error (ERR only)
//   busy, fill_valid/fill_data/fill_addr, err   status and fill return
//   reqD_cache, reqD_cache_write, reqAddrD_mem, reqAddrD_write_mem,
//   data_from_cache                  request to memory controller
//   read_ready_for_dcache, written_data_ack, data_to_cache   memory responses
module dcache_miss_handler
    import dcache_miss_handler_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              miss_req,
    input  logic [ADDR_W-1:0] miss_addr,
    input  logic              miss_dirty,
    input  logic [ADDR_W-1:0] victim_addr,
    input  logic [LINE_W-1:0] victim_data,
    input  logic              err_clr,
    output logic              busy,
    output logic              fill_valid,
    output logic [LINE_W-1:0] fill_data,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              err,
    output logic              reqD_cache,
    output logic              reqD_cache_write,
    output logic [ADDR_W-1:0] reqAddrD_mem,
    output logic [ADDR_W-1:0] reqAddrD_write_mem,
    output logic [LINE_W-1:0] data_from_cache,
    input  logic              read_ready_for_dcache,
    input  logic              written_data_ack,
    input  logic [LINE_W-1:0] data_to_cache
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state, state_n;
    logic               dirty_q, dirty_n;
    logic               wack_seen, wack_seen_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;

    logic               busy_n, fill_valid_n, err_n;
    logic               req_n, req_write_n;
    logic [LINE_W-1:0]  fill_data_n, wdata_n;
    logic [ADDR_W-1:0]  fill_addr_n, raddr_n, waddr_n;

    always_comb begin
        state_n      = state;
        dirty_n      = dirty_q;
        wack_seen_n  = wack_seen;
        cnt_n        = cnt_q;
        busy_n       = busy;
        fill_valid_n = 1'b0;          // single-cycle pulse by default
        fill_data_n  = fill_data;
        fill_addr_n  = fill_addr;
        err_n        = err;
        req_n        = reqD_cache;
        req_write_n  = reqD_cache_write;
        raddr_n      = reqAddrD_mem;
        waddr_n      = reqAddrD_write_mem;
        wdata_n      = data_from_cache;

        case (state)
            ST_IDLE: begin
                if (miss_req) begin
                    state_n     = ST_REQ;
                    raddr_n     = miss_addr;
                    waddr_n     = victim_addr;
                    wdata_n     = victim_data;
                    dirty_n     = miss_dirty;
                    wack_seen_n = 1'b0;
                    cnt_n       = '0;
                    busy_n      = 1'b1;
                    req_n       = 1'b1;
                    req_write_n = miss_dirty;
                end
            end
            ST_REQ: begin
                if (dirty_q && written_data_ack) begin
                    wack_seen_n = 1'b1;
                end
                if (read_ready_for_dcache) begin
                    req_n       = 1'b0;
                    req_write_n = 1'b0;
                    // Read data came back before the write-back was accepted:
                    // the victim may be lost, so flag it instead of filling.
                    if (dirty_q && !wack_seen && !written_data_ack) begin
                        state_n = ST_ERR;
                        err_n   = 1'b1;
                    end else begin
                        state_n      = ST_FILL;
                        fill_valid_n = 1'b1;
                        fill_data_n  = data_to_cache;
                        fill_addr_n  = reqAddrD_mem;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // This is the TIMEOUT-th REQ cycle without read data.
                    state_n     = ST_ERR;
                    err_n       = 1'b1;
                    req_n       = 1'b0;
                    req_write_n = 1'b0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_FILL: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_n = ST_IDLE;
                    err_n   = 1'b0;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
                req_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= ST_IDLE;
            dirty_q            <= 1'b0;
            wack_seen          <= 1'b0;
            cnt_q              <= '0;
            busy               <= 1'b0;
            fill_valid         <= 1'b0;
            fill_data          <= '0;
            fill_addr          <= '0;
            err                <= 1'b0;
            reqD_cache         <= 1'b0;
            reqD_cache_write   <= 1'b0;
            reqAddrD_mem       <= '0;
            reqAddrD_write_mem <= '0;
            data_from_cache    <= '0;
        end else begin
            state              <= state_n;
            dirty_q            <= dirty_n;
            wack_seen          <= wack_seen_n;
            cnt_q              <= cnt_n;
            busy               <= busy_n;
            fill_valid         <= fill_valid_n;
            fill_data          <= fill_data_n;
            fill_addr          <= fill_addr_n;
            err                <= err_n;
            reqD_cache         <= req_n;
            reqD_cache_write   <= req_write_n;
            reqAddrD_mem       <= raddr_n;
            reqAddrD_write_mem <= waddr_n;
            data_from_cache    <= wdata_n;
        end
    end

endmodule

// File: tb/tb_dcache_miss_handler.sv
// Directed self-checking bench for dcache_miss_handler.
// Latency: inputs driven and outputs sampled 1 time unit after each posedge.
// Backpressure: memory responses are modelled inline per scenario.
module tb_dcache_miss_handler;
    import dcache_miss_handler_pkg::*;

    localparam int AW = 20;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          miss_req = 1'b0;
    logic [AW-1:0] miss_addr = '0;
    logic          miss_dirty = 1'b0;
    logic [AW-1:0] victim_addr = '0;
    logic [LW-1:0] victim_data = '0;
    logic          err_clr = 1'b0;
    logic          busy, fill_valid, err, reqD_cache, reqD_cache_write;
    logic [LW-1:0] fill_data, data_from_cache;
    logic [AW-1:0] fill_addr, reqAddrD_mem, reqAddrD_write_mem;
    logic          read_ready_for_dcache = 1'b0;
    logic          written_data_ack = 1'b0;
    logic [LW-1:0] data_to_cache = '0;

    int total = 0;
    int bad   = 0;

    dcache_miss_handler #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(31)) dut (
        .clk(clk), .reset(reset),
        .miss_req(miss_req), .miss_addr(miss_addr), .miss_dirty(miss_dirty),
        .victim_addr(victim_addr), .victim_data(victim_data), .err_clr(err_clr),
        .busy(busy), .fill_valid(fill_valid), .fill_data(fill_data),
        .fill_addr(fill_addr), .err(err),
        .reqD_cache(reqD_cache), .reqD_cache_write(reqD_cache_write),
        .reqAddrD_mem(reqAddrD_mem), .reqAddrD_write_mem(reqAddrD_write_mem),
        .data_from_cache(data_from_cache),
        .read_ready_for_dcache(read_ready_for_dcache),
        .written_data_ack(written_data_ack), .data_to_cache(data_to_cache)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [LW-1:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [LW-1:0] D2 = 128'hCAFE_F00D_1111_2222_3333_4444_5555_6666;
    localparam logic [LW-1:0] VD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    initial begin
        int hi;
        int n;
        int rc, gap, min_gap, rises, fills;
        logic prev;

        // ---- reset state, asynchronous, before any clock edge
        #1 reset = 1'b1;
        #1;
        check("rst_busy", LW'(busy), 0);
        check("rst_req", LW'(reqD_cache), 0);
        check("rst_flags", LW'({fill_valid, err, reqD_cache_write}), 0);
        check("rst_addr", LW'({reqAddrD_mem, reqAddrD_write_mem, fill_addr}), 0);
        check("rst_data", data_from_cache | fill_data, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // ---- clean miss, read data in the 9th REQ cycle
        miss_req = 1'b1; miss_addr = 20'h00ABC; miss_dirty = 1'b0;
        tick();
        miss_req = 1'b0; miss_addr = 20'h55555;
        check("clean_req_rise", LW'({reqD_cache, busy, reqD_cache_write}), LW'(3'b110));
        hi = 0;
        for (int i = 0; i < 9; i++) begin
            if (reqD_cache) hi++;
            if (i == 4) check("clean_addr_hold", LW'(reqAddrD_mem), LW'(20'h00ABC));
            if (i == 8) begin read_ready_for_dcache = 1'b1; data_to_cache = D1; end
            tick();
        end
        read_ready_for_dcache = 1'b0;
        check("clean_req_cycles", LW'(hi), 9);
        check("clean_fill", LW'({fill_valid, reqD_cache, busy}), LW'(3'b101));
        check("clean_fill_data", fill_data, D1);
        check("clean_fill_addr", LW'(fill_addr), LW'(20'h00ABC));
        tick();
        check("clean_done", LW'({fill_valid, busy}), 0);

        // ---- dirty miss, ack and ready in the same cycle
        miss_req = 1'b1; miss_addr = 20'h00200; miss_dirty = 1'b1;
        victim_addr = 20'h00100; victim_data = VD;
        tick();
        miss_req = 1'b0; victim_addr = 20'hFFFFF; victim_data = '0; miss_dirty = 1'b0;
        tick(); tick();
        check("dirty_wr_flag", LW'({reqD_cache, reqD_cache_write}), LW'(2'b11));
        check("dirty_waddr", LW'(reqAddrD_write_mem), LW'(20'h00100));
        check("dirty_wdata", data_from_cache, VD);
        written_data_ack = 1'b1; read_ready_for_dcache = 1'b1; data_to_cache = D2;
        tick();
        written_data_ack = 1'b0; read_ready_for_dcache = 1'b0;
        check("dirty_fill", LW'({fill_valid, err, reqD_cache_write}), LW'(3'b100));
        check("dirty_fill_data", fill_data, D2);
        check("dirty_fill_addr", LW'(fill_addr), LW'(20'h00200));
        tick();

        // ---- dirty miss, ack earlier than ready
        miss_req = 1'b1; miss_addr = 20'h00321; miss_dirty = 1'b1;
        tick();
        miss_req = 1'b0;
        written_data_ack = 1'b1;
        tick();
        written_data_ack = 1'b0;
        tick();
        read_ready_for_dcache = 1'b1; data_to_cache = D1;
        tick();
        read_ready_for_dcache = 1'b0;
        check("early_ack_fill", LW'({fill_valid, err}), LW'(2'b10));
        tick();

        // ---- dirty miss, ready without ack -> ERR
        miss_req = 1'b1; miss_addr = 20'h00400; miss_dirty = 1'b1;
        tick();
        miss_req = 1'b0;
        tick();
        read_ready_for_dcache = 1'b1; data_to_cache = D2;
        tick();
        read_ready_for_dcache = 1'b0;
        check("noack_err", LW'({err, fill_valid, reqD_cache, busy}), LW'(4'b1001));
        read_ready_for_dcache = 1'b1;
        tick();
        read_ready_for_dcache = 1'b0;
        tick();
        check("err_sticky", LW'({err, fill_valid, busy}), LW'(3'b101));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", LW'({err, busy}), 0);

        // ---- err_clr outside ERR does nothing harmful
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr_idle", LW'({err, busy, reqD_cache}), 0);

        // ---- timeout: no read data at all
        miss_req = 1'b1; miss_addr = 20'h00777; miss_dirty = 1'b0;
        tick();
        miss_req = 1'b0;
        n = 0;
        while (reqD_cache && n < 40) begin
            n++;
            tick();
        end
        check("tmo_cycles", LW'(n), 31);
        check("tmo_err", LW'({err, reqD_cache, fill_valid}), LW'(3'b100));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // ---- miss_req held high: back-to-back transactions
        miss_req = 1'b1; miss_addr = 20'h00900; miss_dirty = 1'b0;
        rc = 0; gap = 0; min_gap = 99; rises = 0; fills = 0; prev = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (reqD_cache) begin
                if (!prev) begin
                    rises++;
                    if (rises > 1 && gap < min_gap) min_gap = gap;
                end
                rc++;
                gap = 0;
            end else begin
                rc = 0;
                gap++;
            end
            if (fill_valid) fills++;
            read_ready_for_dcache = reqD_cache && (rc == 2);
            prev = reqD_cache;
            tick();
        end
        miss_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            read_ready_for_dcache = reqD_cache;
            tick();
        end
        read_ready_for_dcache = 1'b0;
        check("b2b_rises", LW'(rises >= 3 && rises <= 7), 1);
        check("b2b_gap", LW'(min_gap >= 1 && min_gap < 99), 1);
        check("b2b_fills", LW'(fills == rises || fills == rises - 1), 1);
        check("b2b_idle", LW'({busy, err}), 0);

        // ---- reset asserted mid-REQ, late read data ignored
        miss_req = 1'b1; miss_addr = 20'h00A0A; miss_dirty = 1'b1; victim_data = VD;
        tick();
        miss_req = 1'b0;
        check("mid_req_up", LW'(reqD_cache), 1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_outs", LW'({busy, reqD_cache, reqD_cache_write, err, fill_valid}), 0);
        check("mid_rst_addr", LW'(reqAddrD_mem) | data_from_cache, 0);
        reset = 1'b0;
        read_ready_for_dcache = 1'b1; written_data_ack = 1'b1; data_to_cache = D1;
        tick();
        read_ready_for_dcache = 1'b0; written_data_ack = 1'b0;
        tick();
        check("late_ready_nofill", LW'({fill_valid, busy, err}), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_miss_handler.md
DCACHE_MISS_HANDLER -- requirements
Module: dcache_miss_handler

Interface
REQ-001 Parameter ADDR_W, 20, line address width.
REQ-002 Parameter LINE_W, 128, cache line width in bits.
REQ-003 Parameter TIMEOUT, 31, maximum cycles spent in REQ before error.
REQ-004 clk  in  1  single clock; all state changes on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 miss_req  in  1  D-cache core requests a line fill; sampled only in IDLE.
REQ-007 miss_addr  in  ADDR_W  line address to read.
REQ-008 miss_dirty  in  1  victim line is dirty and must be written back.
REQ-009 victim_addr  in  ADDR_W  write-back address of the victim line.
REQ-010 victim_data  in  LINE_W  victim line contents.
REQ-011 err_clr  in  1  clears the sticky error and leaves ERR.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 fill_valid  out  1  one-cycle pulse; fill_data/fill_addr valid.
REQ-014 fill_data  out  LINE_W  line returned by memory.
REQ-015 fill_addr  out  ADDR_W  address of the filled line.
REQ-016 err  out  1  sticky protocol/timeout error.
REQ-017 reqD_cache  out  1  read request to memory controller.
REQ-018 reqD_cache_write  out  1  the request carries a write-back.
REQ-019 reqAddrD_mem  out  ADDR_W  read address.
REQ-020 reqAddrD_write_mem  out  ADDR_W  write-back address.
REQ-021 data_from_cache  out  LINE_W  write-back data.
REQ-022 read_ready_for_dcache  in  1  memory read data valid, one cycle.
REQ-023 written_data_ack  in  1  memory accepted the write-back, one cycle.
REQ-024 data_to_cache  in  LINE_W  memory read data.

Function
REQ-025 States: IDLE, REQ, FILL, ERR; all outputs registered.
REQ-026 IDLE: miss_req=1 latches miss_addr, miss_dirty, victim_addr, victim_data; next state REQ.
REQ-027 REQ: reqD_cache=1, reqD_cache_write=latched dirty, address/data outputs hold latched values unchanged throughout.
REQ-028 reqD_cache rises the cycle after miss_req is sampled (1-cycle issue latency).
REQ-029 In REQ, written_data_ack=1 sets an internal wack_seen flag; ignored when not dirty.
REQ-030 In REQ, read_ready_for_dcache=1 captures data_to_cache; next state FILL, reqD_cache and reqD_cache_write drop the same next cycle.
REQ-031 If dirty and wack_seen=0 and written_data_ack=0 in the read_ready cycle -> ERR instead of FILL.
REQ-032 FILL: fill_valid=1 for exactly one cycle with captured data and latched miss_addr; next state IDLE.
REQ-033 Earliest new miss acceptance: the cycle after FILL (guarantees one req-low cycle between transactions).
REQ-034 REQ cycle counter (5 bits, saturating) resets on REQ entry; reaching TIMEOUT without read_ready -> ERR.
REQ-035 ERR: err=1 sticky, reqD_cache=0, no fill; err_clr=1 -> IDLE with err=0 next cycle.
REQ-036 miss_req outside IDLE ignored; read_ready_for_dcache/written_data_ack outside REQ ignored.
REQ-037 err_clr outside ERR has no effect.

Reset
REQ-038 reset=1 forces IDLE immediately; busy, fill_valid, err, reqD_cache, reqD_cache_write, wack_seen=0; address/data outputs=0.
REQ-039 Reset mid-REQ drops reqD_cache asynchronously; any later read_ready is ignored.

Structure
REQ-040 Shared package holds state enum, ADDR_W/LINE_W defaults, TIMEOUT default.
REQ-041 Single flat module; no sub-module.

Verification
REQ-042 Clean miss 0x00ABC, memory ready 9 cycles after req -> reqD_cache high 9 cycles, fill_valid one cycle with data, fill_addr=0x00ABC.
REQ-043 Dirty miss, victim 0x00100/data 0xDEAD..., ack and ready same cycle -> write fields held, reqD_cache_write=1, fill issued, err=0.
REQ-044 Dirty miss, ready without ack -> ERR, err=1, no fill_valid; err_clr -> IDLE, busy=0.
REQ-045 No ready for 31 cycles -> ERR at cycle 31, reqD_cache=0.
REQ-046 miss_req held high continuously -> one req-low cycle between consecutive transactions; misses during busy ignored.
REQ-047 reset asserted mid-REQ -> all outputs 0 without clock edge; late read_ready produces no fill.
